// File: rtl/fp_accumulator.sv
// fp_accumulator: sequential IEEE-754 single-precision accumulator.
// One product is accepted in IDLE and added into the accumulator over five
// stage cycles: UNPACK, ALIGN, ADD, NORM, ROUND. A product tagged in_last
// sends the sum to OUT, where it is held until downstream takes it.
// Build option: define FP_ACC_FTZ_EN to flush denormal inputs and results
// to signed zero. The default build keeps full denormal support.
//
// state  | meaning
// IDLE   | waiting for a product, in_ready high
// UNPACK | split operands into fields, detect NaN/Inf
// ALIGN  | order by magnitude, shift smaller significand right
// ADD    | add or subtract aligned significands
// NORM   | renormalise after carry-out or cancellation
// ROUND  | round to nearest even, write accumulator
// OUT    | finished sum presented until out_ready
module fp_accumulator #(
  parameter logic [31:0] INIT_ACC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] op_q, op_d;
  logic        last_q, last_d;
  logic        spec_q, spec_d;
  logic [31:0] spec_val_q, spec_val_d;
  logic        a_s_q, a_s_d, b_s_q, b_s_d;
  logic [7:0]  a_e_q, a_e_d, b_e_q, b_e_d;
  logic [23:0] a_m_q, a_m_d, b_m_q, b_m_d;
  logic        big_s_q, big_s_d;
  logic        sub_q, sub_d;
  logic        zsign_q, zsign_d;
  logic [9:0]  exp_q, exp_d;
  logic [26:0] mb_q, mb_d;
  logic [26:0] ms_q, ms_d;
  logic [27:0] sum_q, sum_d;
  logic        zero_q, zero_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;

  // Position of the leading one counted from bit 26; 27 when v is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  // Stage temporaries
  logic [7:0]  ua_exp, ub_exp;
  logic [22:0] ua_frac, ub_frac, ua_fe, ub_fe;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic        a_big;
  logic [7:0]  big_e, sm_e, diff;
  logic [23:0] big_m, sm_m;
  logic [52:0] ext;
  logic [4:0]  lz, sh;
  logic [9:0]  lim;
  logic        rup;
  logic [24:0] mant;
  logic [9:0]  e_r;
  logic        hidden;
  logic [22:0] frac;
  logic [31:0] res;

  // Registered state, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= INIT_ACC;
      op_q        <= '0;
      last_q      <= 1'b0;
      spec_q      <= 1'b0;
      spec_val_q  <= '0;
      a_s_q       <= 1'b0;
      b_s_q       <= 1'b0;
      a_e_q       <= '0;
      b_e_q       <= '0;
      a_m_q       <= '0;
      b_m_q       <= '0;
      big_s_q     <= 1'b0;
      sub_q       <= 1'b0;
      zsign_q     <= 1'b0;
      exp_q       <= '0;
      mb_q        <= '0;
      ms_q        <= '0;
      sum_q       <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      last_q      <= last_d;
      spec_q      <= spec_d;
      spec_val_q  <= spec_val_d;
      a_s_q       <= a_s_d;
      b_s_q       <= b_s_d;
      a_e_q       <= a_e_d;
      b_e_q       <= b_e_d;
      a_m_q       <= a_m_d;
      b_m_q       <= b_m_d;
      big_s_q     <= big_s_d;
      sub_q       <= sub_d;
      zsign_q     <= zsign_d;
      exp_q       <= exp_d;
      mb_q        <= mb_d;
      ms_q        <= ms_d;
      sum_q       <= sum_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Next state and per-stage datapath
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    last_d      = last_q;
    spec_d      = spec_q;
    spec_val_d  = spec_val_q;
    a_s_d       = a_s_q;
    b_s_d       = b_s_q;
    a_e_d       = a_e_q;
    b_e_d       = b_e_q;
    a_m_d       = a_m_q;
    b_m_d       = b_m_q;
    big_s_d     = big_s_q;
    sub_d       = sub_q;
    zsign_d     = zsign_q;
    exp_d       = exp_q;
    mb_d        = mb_q;
    ms_d        = ms_q;
    sum_d       = sum_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    ua_exp  = acc_q[30:23];
    ub_exp  = op_q[30:23];
    ua_frac = acc_q[22:0];
    ub_frac = op_q[22:0];
`ifdef FP_ACC_FTZ_EN
    ua_fe   = (ua_exp == 8'd0) ? 23'd0 : ua_frac;
    ub_fe   = (ub_exp == 8'd0) ? 23'd0 : ub_frac;
`else
    ua_fe   = ua_frac;
    ub_fe   = ub_frac;
`endif
    nan_a   = (ua_exp == 8'hFF) && (ua_frac != 23'd0);
    nan_b   = (ub_exp == 8'hFF) && (ub_frac != 23'd0);
    inf_a   = (ua_exp == 8'hFF) && (ua_frac == 23'd0);
    inf_b   = (ub_exp == 8'hFF) && (ub_frac == 23'd0);

    a_big = {a_e_q, a_m_q} >= {b_e_q, b_m_q};
    big_e = a_big ? a_e_q : b_e_q;
    big_m = a_big ? a_m_q : b_m_q;
    sm_e  = a_big ? b_e_q : a_e_q;
    sm_m  = a_big ? b_m_q : a_m_q;
    diff  = big_e - sm_e;
    ext   = {sm_m, 3'b000, 26'd0} >> diff;

    lz  = lzc27(sum_q[26:0]);
    lim = exp_q - 10'd1;
    sh  = ({5'd0, lz} < lim) ? lz : lim[4:0];

    rup  = mb_q[2] & (mb_q[1] | mb_q[0] | mb_q[3]);
    mant = {1'b0, mb_q[26:3]} + {24'd0, rup};
    if (mant[24]) begin
      e_r    = exp_q + 10'd1;
      hidden = 1'b1;
      frac   = mant[23:1];
    end else begin
      e_r    = exp_q;
      hidden = mant[23];
      frac   = mant[22:0];
    end
    if (spec_q)                res = spec_val_q;
    else if (zero_q)           res = {zsign_q, 31'd0};
    else if (e_r >= 10'd255)   res = {big_s_q, 8'hFF, 23'd0};
`ifdef FP_ACC_FTZ_EN
    else if (!hidden)          res = {big_s_q, 31'd0};
`else
    else if (!hidden)          res = {big_s_q, 8'h00, frac};
`endif
    else                       res = {big_s_q, e_r[7:0], frac};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_data;
          last_d  = in_last;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        a_s_d = acc_q[31];
        b_s_d = op_q[31];
        a_e_d = (ua_exp == 8'd0) ? 8'd1 : ua_exp;
        b_e_d = (ub_exp == 8'd0) ? 8'd1 : ub_exp;
        a_m_d = {ua_exp != 8'd0, ua_fe};
        b_m_d = {ub_exp != 8'd0, ub_fe};
        spec_d     = 1'b1;
        spec_val_d = 32'h7FC0_0000;
        if (nan_a || nan_b || (inf_a && inf_b && (acc_q[31] != op_q[31])))
          spec_val_d = 32'h7FC0_0000;
        else if (inf_a)
          spec_val_d = {acc_q[31], 8'hFF, 23'd0};
        else if (inf_b)
          spec_val_d = {op_q[31], 8'hFF, 23'd0};
        else
          spec_d = 1'b0;
        state_d = S_ALIGN;
      end
      S_ALIGN: begin
        big_s_d = a_big ? a_s_q : b_s_q;
        sub_d   = a_s_q != b_s_q;
        zsign_d = a_s_q & b_s_q;
        exp_d   = {2'b00, big_e};
        mb_d    = {big_m, 3'b000};
        if (diff > 8'd26) ms_d = {26'd0, |sm_m};
        else              ms_d = {ext[52:27], ext[26] | (|ext[25:0])};
        state_d = S_ADD;
      end
      S_ADD: begin
        sum_d   = sub_q ? ({1'b0, mb_q} - {1'b0, ms_q})
                        : ({1'b0, mb_q} + {1'b0, ms_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        zero_d = (sum_q == 28'd0);
        if (sum_q[27]) begin
          mb_d  = {sum_q[27:2], sum_q[1] | sum_q[0]};
          exp_d = exp_q + 10'd1;
        end else begin
          mb_d  = sum_q[26:0] << sh;
          exp_d = exp_q - {5'd0, sh};
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        acc_d = res;
        if (last_q) begin
          out_data_d  = res;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = INIT_ACC;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = out_valid_q;
    out_data  = out_data_q;
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator with hand-computed expected sums.
module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fp_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Present one product and hold it for the accepting edge
  task automatic send(input logic [31:0] w, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'd0;
  endtask

  // Wait for the sum, record cycles since the accept edge, and take it
  task automatic take(input string tag, input logic [31:0] exp, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check(tag, out_data, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);

    // 1.0 + 2.0 = 3.0, result visible in the sixth cycle after accept
    send(32'h3F80_0000, 1'b0);
    @(negedge clk);
    check("busy_mid", {31'd0, busy}, 32'd1);
    check("in_ready_mid", {31'd0, in_ready}, 32'd0);
    send(32'h4000_0000, 1'b1);
    take("sum3", 32'h4040_0000, lat);
    check("latency", lat, 32'd6);
    @(negedge clk);
    check("in_ready_after_out", {31'd0, in_ready}, 32'd1);

    // Tie rounds to even
    send(32'h3F80_0000, 1'b0);
    send(32'h3380_0000, 1'b1);
    take("tie_even", 32'h3F80_0000, lat);

    // Above half rounds up; inputs presented while busy must be ignored
    send(32'h3F80_0000, 1'b0);
    send(32'h33C0_0000, 1'b1);
    in_valid = 1'b1; in_data = 32'h7FC0_0000; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0; in_data = 32'd0;
    take("round_up", 32'h3F80_0001, lat);

    // Overflow to +Inf, held 10 cycles by downstream back-pressure
    send(32'h7F7F_FFFF, 1'b0);
    send(32'h7F7F_FFFF, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    check("ovf_valid", {31'd0, out_valid}, 32'd1);
    check("ovf", out_data, 32'h7F80_0000);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_data", out_data, held);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);

    // +Inf + -Inf is the canonical NaN
    send(32'h7F80_0000, 1'b0);
    send(32'hFF80_0000, 1'b1);
    take("inf_minus_inf", 32'h7FC0_0000, lat);

    // Smallest denormal survives unless flushing is built in
    send(32'h0000_0001, 1'b1);
`ifdef FP_ACC_FTZ_EN
    take("denorm", 32'h0000_0000, lat);
`else
    take("denorm", 32'h0000_0001, lat);
`endif

    // Exact cancellation gives +0; 3 - 1 = 2
    send(32'h3F80_0000, 1'b0);
    send(32'hBF80_0000, 1'b1);
    take("cancel", 32'h0000_0000, lat);
    send(32'h4040_0000, 1'b0);
    send(32'hBF80_0000, 1'b1);
    take("sub", 32'h4000_0000, lat);

    // Inf plus finite keeps Inf; a NaN operand gives canonical NaN
    send(32'h7F80_0000, 1'b0);
    send(32'hC000_0000, 1'b1);
    take("inf_finite", 32'h7F80_0000, lat);
    send(32'h7F80_0001, 1'b1);
    take("nan_in", 32'h7FC0_0000, lat);

    // Reset in ALIGN drops the in-flight 2.0
    send(32'h4000_0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    send(32'h3F80_0000, 1'b1);
    take("after_rst", 32'h3F80_0000, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
